// File: rtl/if_stage_pc_unit.sv
// Instruction-fetch stage: program counter, instruction-memory address and the IF/ID
// pipeline register, with freeze, EXE branch redirect, flush and a fetch counter.
module if_stage_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        flush,
  output logic [31:0] instr_mem_addr,
  input  logic [31:0] instr_mem_data,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        squash;
  logic        load;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = {branch_addr[31:2], 2'b00};
  assign next_pc       = branch_taken ? branch_target : pc_plus4;

  // A redirect or flush squashes the wrong-path fetch even while frozen.
  assign squash = branch_taken | flush;
  assign load   = ~squash & ~freeze;

  // The branch beats freeze so a stalled front end never drops a redirect.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken || !freeze) begin
      pc_d = next_pc;
    end
  end

  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    if (squash) begin
      if_id_pc_d    = 32'h0000_0000;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (load) begin
      if_id_pc_d    = pc_plus4;
      if_id_instr_d = instr_mem_data;
      if_id_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign instr_mem_addr = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_valid    = if_id_valid_q;
  assign fetch_count    = fetch_count_q;

endmodule
